// File: rtl/tlrot_host_arbiter.sv
// Two-host TL-UL arbiter in front of the RoT register port: round-robin A-channel
// grant locked across backpressure, source-tagged D routing, per-host outstanding limits.
module tlrot_host_arbiter #(
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,

   input  logic        h0_a_valid,
   output logic        h0_a_ready,
   input  logic [2:0]  h0_a_bits_opcode,
   input  logic [2:0]  h0_a_bits_param,
   input  logic [1:0]  h0_a_bits_size,
   input  logic [7:0]  h0_a_bits_source,
   input  logic [31:0] h0_a_bits_address,
   input  logic [3:0]  h0_a_bits_mask,
   input  logic [31:0] h0_a_bits_data,
   output logic        h0_d_valid,
   input  logic        h0_d_ready,
   output logic [2:0]  h0_d_bits_opcode,
   output logic [2:0]  h0_d_bits_param,
   output logic [1:0]  h0_d_bits_size,
   output logic [7:0]  h0_d_bits_source,
   output logic        h0_d_bits_sink,
   output logic [31:0] h0_d_bits_data,
   output logic        h0_d_bits_denied,

   input  logic        h1_a_valid,
   output logic        h1_a_ready,
   input  logic [2:0]  h1_a_bits_opcode,
   input  logic [2:0]  h1_a_bits_param,
   input  logic [1:0]  h1_a_bits_size,
   input  logic [7:0]  h1_a_bits_source,
   input  logic [31:0] h1_a_bits_address,
   input  logic [3:0]  h1_a_bits_mask,
   input  logic [31:0] h1_a_bits_data,
   output logic        h1_d_valid,
   input  logic        h1_d_ready,
   output logic [2:0]  h1_d_bits_opcode,
   output logic [2:0]  h1_d_bits_param,
   output logic [1:0]  h1_d_bits_size,
   output logic [7:0]  h1_d_bits_source,
   output logic        h1_d_bits_sink,
   output logic [31:0] h1_d_bits_data,
   output logic        h1_d_bits_denied,

   output logic        dn_a_valid,
   input  logic        dn_a_ready,
   output logic [2:0]  dn_a_bits_opcode,
   output logic [2:0]  dn_a_bits_param,
   output logic [1:0]  dn_a_bits_size,
   output logic [7:0]  dn_a_bits_source,
   output logic [31:0] dn_a_bits_address,
   output logic [3:0]  dn_a_bits_mask,
   output logic [31:0] dn_a_bits_data,
   input  logic        dn_d_valid,
   output logic        dn_d_ready,
   input  logic [2:0]  dn_d_bits_opcode,
   input  logic [2:0]  dn_d_bits_param,
   input  logic [1:0]  dn_d_bits_size,
   input  logic [7:0]  dn_d_bits_source,
   input  logic        dn_d_bits_sink,
   input  logic [31:0] dn_d_bits_data,
   input  logic        dn_d_bits_denied,

   output logic        busy_o,
   output logic        unexp_rsp_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   // Handshakes: a beat transfers on a channel only in a cycle where both valid and
   // ready are high; valid never depends on ready, and a raised valid holds its payload.
   logic            lock_q, lock_id_q, last_gnt_q, unexp_q;
   logic [CntW-1:0] cnt0_q, cnt1_q;

   logic elig0, elig1;
   logic gnt, gnt_valid;
   logic a_req, a_fire;
   logic rsp_id, d_fire;
   logic inc0, inc1, dec0, dec1;
   logic unexp_hit;

   assign elig0 = h0_a_valid & (cnt0_q < MaxCnt);
   assign elig1 = h1_a_valid & (cnt1_q < MaxCnt);

   always_comb begin
      gnt       = 1'b0;
      gnt_valid = 1'b0;
      if (lock_q) begin
         gnt       = lock_id_q;
         gnt_valid = lock_id_q ? elig1 : elig0;
      end else if (elig0 && elig1) begin
         gnt       = ~last_gnt_q;
         gnt_valid = 1'b1;
      end else if (elig0) begin
         gnt       = 1'b0;
         gnt_valid = 1'b1;
      end else if (elig1) begin
         gnt       = 1'b1;
         gnt_valid = 1'b1;
      end
   end

   assign a_req  = gnt_valid & ~rst_ni;
   assign a_fire = a_req & dn_a_ready;

   assign dn_a_valid        = a_req;
   assign dn_a_bits_opcode  = gnt ? h1_a_bits_opcode  : h0_a_bits_opcode;
   assign dn_a_bits_param   = gnt ? h1_a_bits_param   : h0_a_bits_param;
   assign dn_a_bits_size    = gnt ? h1_a_bits_size    : h0_a_bits_size;
   assign dn_a_bits_source  = {gnt, gnt ? h1_a_bits_source[6:0] : h0_a_bits_source[6:0]};
   assign dn_a_bits_address = gnt ? h1_a_bits_address : h0_a_bits_address;
   assign dn_a_bits_mask    = gnt ? h1_a_bits_mask    : h0_a_bits_mask;
   assign dn_a_bits_data    = gnt ? h1_a_bits_data    : h0_a_bits_data;

   assign h0_a_ready = a_req & ~gnt & dn_a_ready;
   assign h1_a_ready = a_req &  gnt & dn_a_ready;

   // The top source bit carries the issuing host; it is stripped before the response leaves.
   assign rsp_id     = dn_d_bits_source[7];
   assign h0_d_valid = dn_d_valid & ~rsp_id & ~rst_ni;
   assign h1_d_valid = dn_d_valid &  rsp_id & ~rst_ni;
   assign dn_d_ready = ~rst_ni & (rsp_id ? h1_d_ready : h0_d_ready);
   assign d_fire     = dn_d_valid & dn_d_ready;

   assign h0_d_bits_opcode = dn_d_bits_opcode;
   assign h0_d_bits_param  = dn_d_bits_param;
   assign h0_d_bits_size   = dn_d_bits_size;
   assign h0_d_bits_source = {1'b0, dn_d_bits_source[6:0]};
   assign h0_d_bits_sink   = dn_d_bits_sink;
   assign h0_d_bits_data   = dn_d_bits_data;
   assign h0_d_bits_denied = dn_d_bits_denied;

   assign h1_d_bits_opcode = dn_d_bits_opcode;
   assign h1_d_bits_param  = dn_d_bits_param;
   assign h1_d_bits_size   = dn_d_bits_size;
   assign h1_d_bits_source = {1'b0, dn_d_bits_source[6:0]};
   assign h1_d_bits_sink   = dn_d_bits_sink;
   assign h1_d_bits_data   = dn_d_bits_data;
   assign h1_d_bits_denied = dn_d_bits_denied;

   assign inc0 = a_fire & ~gnt;
   assign inc1 = a_fire &  gnt;
   assign dec0 = d_fire & ~rsp_id;
   assign dec1 = d_fire &  rsp_id;
   assign unexp_hit = (dec0 && cnt0_q == '0) || (dec1 && cnt1_q == '0);

   // A full counter blocks its host's grant, so increments never overflow;
   // a response with nothing outstanding saturates at zero.
   function automatic logic [CntW-1:0] next_cnt(input logic [CntW-1:0] cnt,
                                                input logic inc, input logic dec);
      logic [CntW-1:0] res;
      res = cnt;
      if (inc && !dec) begin
         res = cnt + CntOne;
      end else if (dec && !inc && cnt != '0) begin
         res = cnt - CntOne;
      end
      return res;
   endfunction

   always_ff @(posedge clk_i or posedge rst_ni) begin
      if (rst_ni) begin
         lock_q     <= 1'b0;
         lock_id_q  <= 1'b0;
         last_gnt_q <= 1'b1;
         cnt0_q     <= '0;
         cnt1_q     <= '0;
         unexp_q    <= 1'b0;
      end else begin
         if (a_fire) begin
            lock_q     <= 1'b0;
            last_gnt_q <= gnt;
         end else if (a_req) begin
            lock_q    <= 1'b1;
            lock_id_q <= gnt;
         end else begin
            lock_q <= 1'b0;
         end
         cnt0_q <= next_cnt(cnt0_q, inc0, dec0);
         cnt1_q <= next_cnt(cnt1_q, inc1, dec1);
         if (unexp_hit) begin
            unexp_q <= 1'b1;
         end
      end
   end

   assign busy_o      = ~rst_ni & ((cnt0_q != '0) | (cnt1_q != '0));
   assign unexp_rsp_o = ~rst_ni & unexp_q;

   h0_source_msb_zero: assert property (@(posedge clk_i) disable iff (rst_ni)
      h0_a_valid |-> !h0_a_bits_source[7]);
   h1_source_msb_zero: assert property (@(posedge clk_i) disable iff (rst_ni)
      h1_a_valid |-> !h1_a_bits_source[7]);
   locked_payload_stable: assert property (@(posedge clk_i) disable iff (rst_ni)
      (lock_q && dn_a_valid) |-> ($stable(dn_a_bits_address) && $stable(dn_a_bits_source)));

endmodule

// File: tb/tb_tlrot_host_arbiter.sv
// Bench for tlrot_host_arbiter: directed vector table, hand-written lock/reset/unexpected
// sequences, then randomized traffic against a transaction-level reference model.
module tb_tlrot_host_arbiter;

   localparam int MAX = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        h0_a_valid, h0_a_ready, h1_a_valid, h1_a_ready;
   logic [2:0]  h0_a_bits_opcode, h0_a_bits_param, h1_a_bits_opcode, h1_a_bits_param;
   logic [1:0]  h0_a_bits_size, h1_a_bits_size;
   logic [7:0]  h0_a_bits_source, h1_a_bits_source;
   logic [31:0] h0_a_bits_address, h0_a_bits_data, h1_a_bits_address, h1_a_bits_data;
   logic [3:0]  h0_a_bits_mask, h1_a_bits_mask;
   logic        h0_d_valid, h0_d_ready, h1_d_valid, h1_d_ready;
   logic [2:0]  h0_d_bits_opcode, h0_d_bits_param, h1_d_bits_opcode, h1_d_bits_param;
   logic [1:0]  h0_d_bits_size, h1_d_bits_size;
   logic [7:0]  h0_d_bits_source, h1_d_bits_source;
   logic        h0_d_bits_sink, h0_d_bits_denied, h1_d_bits_sink, h1_d_bits_denied;
   logic [31:0] h0_d_bits_data, h1_d_bits_data;
   logic        dn_a_valid, dn_a_ready, dn_d_valid, dn_d_ready;
   logic [2:0]  dn_a_bits_opcode, dn_a_bits_param, dn_d_bits_opcode, dn_d_bits_param;
   logic [1:0]  dn_a_bits_size, dn_d_bits_size;
   logic [7:0]  dn_a_bits_source, dn_d_bits_source;
   logic [31:0] dn_a_bits_address, dn_a_bits_data, dn_d_bits_data;
   logic [3:0]  dn_a_bits_mask;
   logic        dn_d_bits_sink, dn_d_bits_denied;
   logic        busy_o, unexp_rsp_o;

   tlrot_host_arbiter #(.MaxOutstanding(MAX)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .h0_a_valid(h0_a_valid), .h0_a_ready(h0_a_ready),
      .h0_a_bits_opcode(h0_a_bits_opcode), .h0_a_bits_param(h0_a_bits_param),
      .h0_a_bits_size(h0_a_bits_size), .h0_a_bits_source(h0_a_bits_source),
      .h0_a_bits_address(h0_a_bits_address), .h0_a_bits_mask(h0_a_bits_mask),
      .h0_a_bits_data(h0_a_bits_data),
      .h0_d_valid(h0_d_valid), .h0_d_ready(h0_d_ready),
      .h0_d_bits_opcode(h0_d_bits_opcode), .h0_d_bits_param(h0_d_bits_param),
      .h0_d_bits_size(h0_d_bits_size), .h0_d_bits_source(h0_d_bits_source),
      .h0_d_bits_sink(h0_d_bits_sink), .h0_d_bits_data(h0_d_bits_data),
      .h0_d_bits_denied(h0_d_bits_denied),
      .h1_a_valid(h1_a_valid), .h1_a_ready(h1_a_ready),
      .h1_a_bits_opcode(h1_a_bits_opcode), .h1_a_bits_param(h1_a_bits_param),
      .h1_a_bits_size(h1_a_bits_size), .h1_a_bits_source(h1_a_bits_source),
      .h1_a_bits_address(h1_a_bits_address), .h1_a_bits_mask(h1_a_bits_mask),
      .h1_a_bits_data(h1_a_bits_data),
      .h1_d_valid(h1_d_valid), .h1_d_ready(h1_d_ready),
      .h1_d_bits_opcode(h1_d_bits_opcode), .h1_d_bits_param(h1_d_bits_param),
      .h1_d_bits_size(h1_d_bits_size), .h1_d_bits_source(h1_d_bits_source),
      .h1_d_bits_sink(h1_d_bits_sink), .h1_d_bits_data(h1_d_bits_data),
      .h1_d_bits_denied(h1_d_bits_denied),
      .dn_a_valid(dn_a_valid), .dn_a_ready(dn_a_ready),
      .dn_a_bits_opcode(dn_a_bits_opcode), .dn_a_bits_param(dn_a_bits_param),
      .dn_a_bits_size(dn_a_bits_size), .dn_a_bits_source(dn_a_bits_source),
      .dn_a_bits_address(dn_a_bits_address), .dn_a_bits_mask(dn_a_bits_mask),
      .dn_a_bits_data(dn_a_bits_data),
      .dn_d_valid(dn_d_valid), .dn_d_ready(dn_d_ready),
      .dn_d_bits_opcode(dn_d_bits_opcode), .dn_d_bits_param(dn_d_bits_param),
      .dn_d_bits_size(dn_d_bits_size), .dn_d_bits_source(dn_d_bits_source),
      .dn_d_bits_sink(dn_d_bits_sink), .dn_d_bits_data(dn_d_bits_data),
      .dn_d_bits_denied(dn_d_bits_denied),
      .busy_o(busy_o), .unexp_rsp_o(unexp_rsp_o)
   );

   always #5 clk_i = ~clk_i;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic idle_inputs();
      h0_a_valid = 1'b0; h1_a_valid = 1'b0;
      h0_a_bits_opcode = 3'd4; h0_a_bits_param = 3'd0; h0_a_bits_size = 2'd2;
      h0_a_bits_source = 8'h00; h0_a_bits_address = 32'h0000_1000;
      h0_a_bits_mask = 4'hf; h0_a_bits_data = 32'h0;
      h1_a_bits_opcode = 3'd4; h1_a_bits_param = 3'd0; h1_a_bits_size = 2'd2;
      h1_a_bits_source = 8'h00; h1_a_bits_address = 32'h0000_2000;
      h1_a_bits_mask = 4'hf; h1_a_bits_data = 32'h0;
      h0_d_ready = 1'b0; h1_d_ready = 1'b0;
      dn_a_ready = 1'b0; dn_d_valid = 1'b0;
      dn_d_bits_opcode = 3'd1; dn_d_bits_param = 3'd0; dn_d_bits_size = 2'd2;
      dn_d_bits_source = 8'h00; dn_d_bits_sink = 1'b0;
      dn_d_bits_data = 32'h0; dn_d_bits_denied = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_ni = 1'b1;
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b0;
   endtask

   typedef struct packed {
      logic       h0v; logic [7:0] h0s; logic h1v; logic [7:0] h1s;
      logic       ar;  logic dv; logic [7:0] ds; logic h0dr; logic h1dr;
      logic       eav; logic [7:0] eas; logic e0ar; logic e1ar;
      logic       e0dv; logic e1dv; logic edr; logic ebusy; logic eunexp;
   } vec_t;

   vec_t vecs[14];

   // Reference-model state for the random phase.
   int         m_cnt[2];
   int         m_pref, m_hold;
   logic       m_unexp;
   logic       hv[2];
   logic [7:0] hsrc[2];
   logic [31:0] haddr[2], hdata[2];
   logic [7:0] exp_q[$];

   initial begin
      rst_ni = 1'b1;
      idle_inputs();

      // Single read, round-robin alternation, counter saturation, same-cycle A+D.
      //             h0v h0s    h1v h1s    ar dv ds     0dr 1dr eav eas    0ar 1ar 0dv 1dv dr busy unx
      vecs[0]  = '{1'b1,8'h05,1'b0,8'h00,1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,8'h05,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
      vecs[1]  = '{1'b0,8'h00,1'b0,8'h00,1'b1,1'b1,8'h05,1'b1,1'b0, 1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0};
      vecs[2]  = '{1'b0,8'h00,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,1'b1, 1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[3]  = '{1'b1,8'h11,1'b1,8'h22,1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,8'hA2,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0};
      vecs[4]  = '{1'b1,8'h11,1'b1,8'h22,1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,8'h11,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
      vecs[5]  = '{1'b1,8'h11,1'b1,8'h22,1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,8'hA2,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0};
      vecs[6]  = '{1'b1,8'h11,1'b1,8'h22,1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,8'h11,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
      vecs[7]  = '{1'b1,8'h11,1'b1,8'h22,1'b1,1'b0,8'h00,1'b1,1'b0, 1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
      vecs[8]  = '{1'b1,8'h11,1'b1,8'h22,1'b1,1'b1,8'hA2,1'b0,1'b1, 1'b0,8'h00,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0};
      vecs[9]  = '{1'b1,8'h11,1'b1,8'h22,1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,8'hA2,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0};
      vecs[10] = '{1'b1,8'h11,1'b0,8'h00,1'b1,1'b1,8'h11,1'b1,1'b0, 1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0};
      vecs[11] = '{1'b1,8'h11,1'b0,8'h00,1'b1,1'b1,8'h11,1'b1,1'b0, 1'b1,8'h11,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0};
      vecs[12] = '{1'b1,8'h11,1'b0,8'h00,1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,8'h11,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
      vecs[13] = '{1'b1,8'h11,1'b0,8'h00,1'b1,1'b0,8'h00,1'b1,1'b0, 1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};

      // Outputs held quiet while reset is asserted, even with live inputs.
      h0_a_valid = 1'b1; h1_a_valid = 1'b1; dn_a_ready = 1'b1;
      dn_d_valid = 1'b1; h0_d_ready = 1'b1; h1_d_ready = 1'b1;
      @(negedge clk_i);
      chk("rst_dn_a_valid", dn_a_valid, 0);
      chk("rst_h0_a_ready", h0_a_ready, 0);
      chk("rst_h1_a_ready", h1_a_ready, 0);
      chk("rst_h0_d_valid", h0_d_valid, 0);
      chk("rst_dn_d_ready", dn_d_ready, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_unexp", unexp_rsp_o, 0);
      do_reset();

      for (int i = 0; i < 14; i++) begin
         h0_a_valid = vecs[i].h0v; h0_a_bits_source = vecs[i].h0s;
         h1_a_valid = vecs[i].h1v; h1_a_bits_source = vecs[i].h1s;
         dn_a_ready = vecs[i].ar;
         dn_d_valid = vecs[i].dv; dn_d_bits_source = vecs[i].ds;
         dn_d_bits_data = 32'h5a00_0000 + 32'(i);
         h0_d_ready = vecs[i].h0dr; h1_d_ready = vecs[i].h1dr;
         @(negedge clk_i);
         chk($sformatf("tbl%0d_dn_a_valid", i), dn_a_valid, vecs[i].eav);
         if (vecs[i].eav) begin
            chk($sformatf("tbl%0d_dn_a_source", i), dn_a_bits_source, vecs[i].eas);
            chk($sformatf("tbl%0d_dn_a_addr", i), dn_a_bits_address,
                vecs[i].eas[7] ? 32'h0000_2000 : 32'h0000_1000);
         end
         chk($sformatf("tbl%0d_h0_a_ready", i), h0_a_ready, vecs[i].e0ar);
         chk($sformatf("tbl%0d_h1_a_ready", i), h1_a_ready, vecs[i].e1ar);
         chk($sformatf("tbl%0d_h0_d_valid", i), h0_d_valid, vecs[i].e0dv);
         chk($sformatf("tbl%0d_h1_d_valid", i), h1_d_valid, vecs[i].e1dv);
         chk($sformatf("tbl%0d_dn_d_ready", i), dn_d_ready, vecs[i].edr);
         chk($sformatf("tbl%0d_busy", i), busy_o, vecs[i].ebusy);
         chk($sformatf("tbl%0d_unexp", i), unexp_rsp_o, vecs[i].eunexp);
         if (vecs[i].dv) begin
            chk($sformatf("tbl%0d_d_source", i),
                vecs[i].ds[7] ? h1_d_bits_source : h0_d_bits_source, {1'b0, vecs[i].ds[6:0]});
            chk($sformatf("tbl%0d_d_data", i),
                vecs[i].ds[7] ? h1_d_bits_data : h0_d_bits_data, 32'h5a00_0000 + 32'(i));
         end
         next_cycle();
      end

      // Grant lock under backpressure: h1 holds the grant although h0 would win round-robin.
      do_reset();
      h1_a_valid = 1'b1; h1_a_bits_source = 8'h33; h1_a_bits_data = 32'hcafe_0001;
      @(negedge clk_i);
      chk("lock_c1_source", dn_a_bits_source, 8'hB3);
      chk("lock_c1_h1_ready", h1_a_ready, 0);
      next_cycle();
      h0_a_valid = 1'b1; h0_a_bits_source = 8'h44; h0_a_bits_data = 32'hbeef_0002;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk_i);
         chk("lock_hold_source", dn_a_bits_source, 8'hB3);
         chk("lock_hold_addr", dn_a_bits_address, 32'h0000_2000);
         chk("lock_hold_data", dn_a_bits_data, 32'hcafe_0001);
         chk("lock_hold_h0_ready", h0_a_ready, 0);
         next_cycle();
      end
      dn_a_ready = 1'b1;
      @(negedge clk_i);
      chk("lock_fire_source", dn_a_bits_source, 8'hB3);
      chk("lock_fire_h1_ready", h1_a_ready, 1);
      chk("lock_fire_h0_ready", h0_a_ready, 0);
      next_cycle();
      h1_a_valid = 1'b0;
      @(negedge clk_i);
      chk("lock_next_source", dn_a_bits_source, 8'h44);
      chk("lock_next_h0_ready", h0_a_ready, 1);
      next_cycle();

      // Reset with both hosts outstanding and the grant locked.
      h0_a_valid = 1'b0;
      h1_a_valid = 1'b1; h1_a_bits_source = 8'h55; dn_a_ready = 1'b0;
      next_cycle();
      h0_a_valid = 1'b1;
      @(negedge clk_i);
      chk("rstmid_locked_source", dn_a_bits_source, 8'hD5);
      chk("rstmid_busy_before", busy_o, 1);
      #2;
      rst_ni = 1'b1;
      dn_a_ready = 1'b1; dn_d_valid = 1'b1; dn_d_bits_source = 8'h05;
      h0_d_ready = 1'b1; h1_d_ready = 1'b1;
      #1;
      chk("rstmid_dn_a_valid", dn_a_valid, 0);
      chk("rstmid_h0_a_ready", h0_a_ready, 0);
      chk("rstmid_h1_a_ready", h1_a_ready, 0);
      chk("rstmid_h0_d_valid", h0_d_valid, 0);
      chk("rstmid_h1_d_valid", h1_d_valid, 0);
      chk("rstmid_dn_d_ready", dn_d_ready, 0);
      chk("rstmid_busy", busy_o, 0);
      next_cycle();
      rst_ni = 1'b0;
      dn_d_valid = 1'b0;
      h0_a_valid = 1'b1; h0_a_bits_source = 8'h44;
      h1_a_valid = 1'b1; h1_a_bits_source = 8'h55;
      @(negedge clk_i);
      chk("post_rst_busy", busy_o, 0);
      chk("post_rst_grant_source", dn_a_bits_source, 8'h44);
      chk("post_rst_h0_ready", h0_a_ready, 1);
      next_cycle();

      // Response for host 1 with nothing outstanding there: passes through, flag sticks.
      h0_a_valid = 1'b0; h1_a_valid = 1'b0;
      dn_d_valid = 1'b1; dn_d_bits_source = 8'h83; h0_d_ready = 1'b0; h1_d_ready = 1'b1;
      @(negedge clk_i);
      chk("unexp_h1_d_valid", h1_d_valid, 1);
      chk("unexp_h1_d_source", h1_d_bits_source, 8'h03);
      chk("unexp_h0_d_valid", h0_d_valid, 0);
      chk("unexp_before", unexp_rsp_o, 0);
      next_cycle();
      dn_d_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         chk("unexp_sticky", unexp_rsp_o, 1);
         chk("unexp_busy_h0", busy_o, 1);
         next_cycle();
      end

      // Randomized traffic against the reference model.
      do_reset();
      @(negedge clk_i);
      chk("rand_reset_unexp", unexp_rsp_o, 0);
      next_cycle();
      m_cnt[0] = 0; m_cnt[1] = 0; m_pref = 0; m_hold = -1; m_unexp = 1'b0;
      hv[0] = 1'b0; hv[1] = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic       ev[2];
         logic       exp_v, a_fire, d_fire, r, dr;
         int         g;
         logic [7:0] ds;
         for (int h = 0; h < 2; h++) begin
            if (!hv[h] && $urandom_range(0, 2) != 0) begin
               hv[h]    = 1'b1;
               hsrc[h]  = {1'b0, 7'($urandom)};
               haddr[h] = $urandom;
               hdata[h] = $urandom;
            end
         end
         h0_a_valid = hv[0]; h0_a_bits_source = hsrc[0];
         h0_a_bits_address = haddr[0]; h0_a_bits_data = hdata[0];
         h1_a_valid = hv[1]; h1_a_bits_source = hsrc[1];
         h1_a_bits_address = haddr[1]; h1_a_bits_data = hdata[1];
         dn_a_ready = ($urandom_range(0, 3) != 0);
         if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) begin
            dn_d_valid = 1'b1; ds = exp_q[0];
         end else begin
            dn_d_valid = 1'b0; ds = 8'($urandom);
         end
         dn_d_bits_source = ds;
         dn_d_bits_data = $urandom;
         h0_d_ready = $urandom_range(0, 1);
         h1_d_ready = $urandom_range(0, 1);

         @(negedge clk_i);
         ev[0] = hv[0] && m_cnt[0] < MAX;
         ev[1] = hv[1] && m_cnt[1] < MAX;
         g = 0; exp_v = 1'b0;
         if (m_hold >= 0) begin
            g = m_hold; exp_v = ev[m_hold];
         end else if (ev[0] && ev[1]) begin
            g = m_pref; exp_v = 1'b1;
         end else if (ev[0] || ev[1]) begin
            g = ev[1] ? 1 : 0; exp_v = 1'b1;
         end
         a_fire = exp_v && dn_a_ready;
         chk("rand_dn_a_valid", dn_a_valid, exp_v);
         if (exp_v) begin
            chk("rand_dn_a_source", dn_a_bits_source, {g[0], hsrc[g][6:0]});
            chk("rand_dn_a_addr", dn_a_bits_address, haddr[g]);
            chk("rand_dn_a_data", dn_a_bits_data, hdata[g]);
         end
         chk("rand_h0_a_ready", h0_a_ready, a_fire && g == 0);
         chk("rand_h1_a_ready", h1_a_ready, a_fire && g == 1);
         r  = ds[7];
         dr = r ? h1_d_ready : h0_d_ready;
         d_fire = dn_d_valid && dr;
         chk("rand_h0_d_valid", h0_d_valid, dn_d_valid && !r);
         chk("rand_h1_d_valid", h1_d_valid, dn_d_valid && r);
         chk("rand_dn_d_ready", dn_d_ready, dr);
         if (dn_d_valid) begin
            chk("rand_d_source", r ? h1_d_bits_source : h0_d_bits_source, {1'b0, ds[6:0]});
            chk("rand_d_data", r ? h1_d_bits_data : h0_d_bits_data, dn_d_bits_data);
         end
         chk("rand_busy", busy_o, (m_cnt[0] + m_cnt[1]) > 0);
         chk("rand_unexp", unexp_rsp_o, m_unexp);

         if (d_fire) begin
            void'(exp_q.pop_front());
            if (m_cnt[r] == 0) m_unexp = 1'b1;
         end
         if (a_fire && d_fire && g == int'(r)) begin
            // request in, response out on the same host: count unchanged
         end else begin
            if (a_fire) m_cnt[g]++;
            if (d_fire && m_cnt[r] > 0) m_cnt[r]--;
         end
         if (a_fire) begin
            exp_q.push_back({g[0], hsrc[g][6:0]});
            hv[g]  = 1'b0;
            m_pref = 1 - g;
            m_hold = -1;
         end else if (exp_v) begin
            m_hold = g;
         end else begin
            m_hold = -1;
         end
         next_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
